// File: rtl/keccak_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// keccak_sponge_ctrl
//   Initiator-side SHAKE256 sponge controller. Absorbs 64-bit message words
//   into the Keccak state by XOR writes, applies 0x1F ... 0x80 padding, starts
//   permutations through the core's EN/DONE handshake and squeezes OUT_WORDS
//   output words.
//
// Ports
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   START             request pulse, honoured only while idle
//   IN_DATA/VALID/LAST/BYTES, IN_READY   message stream (little-endian bytes)
//   STATE_CLR         one-cycle pulse zeroing the 1600-bit state
//   STATE_WE/IDX/WDATA XOR write of one lane; STATE_IDX also addresses reads
//   STATE_RDATA       combinational read of lane STATE_IDX
//   PERM_EN/PERM_DONE permutation start / completion pulses
//   OUT_DATA/VALID/READY squeezed output stream
//   BUSY, DONE        activity flag, end-of-request pulse
// -----------------------------------------------------------------------------
module keccak_sponge_ctrl #(
  parameter int RATE_WORDS = 17,
  parameter int OUT_WORDS  = 4,
  parameter int IDX_W      = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [63:0]      IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  input  logic [3:0]       IN_BYTES,
  output logic             IN_READY,
  output logic             STATE_CLR,
  output logic             STATE_WE,
  output logic [IDX_W-1:0] STATE_IDX,
  output logic [63:0]      STATE_WDATA,
  input  logic [63:0]      STATE_RDATA,
  output logic             PERM_EN,
  input  logic             PERM_DONE,
  output logic [63:0]      OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PAD, S_PERM, S_SQUEEZE} state_t;

  localparam int               OCNT_W    = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATE_WORDS - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OUT_WORDS - 1);
  localparam logic [63:0]      PAD_LO    = 64'h0000_0000_0000_001F;
  localparam logic [63:0]      PAD_HI    = 64'h8000_0000_0000_0000;

  state_t              state_q, state_d, ret_q, ret_d;
  logic [IDX_W-1:0]    aidx_q, aidx_d, sidx_q, sidx_d;
  logic [OCNT_W-1:0]   ocnt_q, ocnt_d;
  logic                pad_hi_q, pad_hi_d;   // only the 0x80 lane write remains
  logic                launch_q, launch_d;   // PERM_EN due next cycle
  logic                in_ready_q, in_ready_d;
  logic                state_clr_q, state_clr_d;
  logic                state_we_q, state_we_d;
  logic [IDX_W-1:0]    state_idx_q, state_idx_d;
  logic [63:0]         state_wdata_q, state_wdata_d;
  logic                perm_en_q, perm_en_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic fire, in_full, at_last_lane;

  // Keep the low nbytes bytes, put the 0x1F domain byte right after them and
  // optionally fold in the final 0x80 when this is already the last rate lane.
  function automatic logic [63:0] pad_last(input logic [63:0] data,
                                           input logic [3:0]  nbytes,
                                           input logic        with_hi);
    logic [63:0] w;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(nbytes))       w[8*b +: 8] = data[8*b +: 8];
      else if (b == int'(nbytes)) w[8*b +: 8] = 8'h1F;
    end
    if (with_hi) w[63:56] = w[63:56] ^ 8'h80;
    return w;
  endfunction

  // IN_READY is a flop, so acceptance never depends combinationally on IN_VALID.
  assign fire         = IN_VALID && in_ready_q;
  assign in_full      = (IN_BYTES >= 4'd8);
  assign at_last_lane = (aidx_q == LAST_LANE);

  always_comb begin
    // NOTE: every _d gets a default here so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    ret_d         = ret_q;
    aidx_d        = aidx_q;
    sidx_d        = sidx_q;
    ocnt_d        = ocnt_q;
    pad_hi_d      = pad_hi_q;
    launch_d      = launch_q;
    in_ready_d    = in_ready_q;
    state_idx_d   = state_idx_q;
    out_valid_d   = out_valid_q;
    state_clr_d   = 1'b0;
    state_we_d    = 1'b0;
    state_wdata_d = '0;
    perm_en_d     = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_clr_d = 1'b1;
          aidx_d      = '0;
          sidx_d      = '0;
          ocnt_d      = '0;
          pad_hi_d    = 1'b0;
          state_idx_d = '0;
          in_ready_d  = 1'b1;
          state_d     = S_ABSORB;
        end
      end

      S_ABSORB: begin
        if (fire) begin
          state_we_d  = 1'b1;
          state_idx_d = aidx_q;
          if (!IN_LAST || in_full) begin
            state_wdata_d = IN_DATA;
            aidx_d        = aidx_q + IDX_W'(1);
            if (at_last_lane) begin
              // Block full: permute, then either keep absorbing or pad at lane 0.
              in_ready_d = 1'b0;
              aidx_d     = '0;
              launch_d   = 1'b1;
              ret_d      = IN_LAST ? S_PAD : S_ABSORB;
              state_d    = S_PERM;
            end else if (IN_LAST) begin
              in_ready_d = 1'b0;
              pad_hi_d   = 1'b0;
              state_d    = S_PAD;
            end
          end else begin
            state_wdata_d = pad_last(IN_DATA, IN_BYTES, at_last_lane);
            in_ready_d    = 1'b0;
            if (at_last_lane) begin
              launch_d = 1'b1;
              ret_d    = S_SQUEEZE;
              state_d  = S_PERM;
            end else begin
              pad_hi_d = 1'b1;
              state_d  = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        state_we_d = 1'b1;
        if (pad_hi_q || at_last_lane) begin
          // Either the lone 0x80 write or the combined 0x80..1F word.
          state_idx_d   = LAST_LANE;
          state_wdata_d = pad_hi_q ? PAD_HI : (PAD_HI | PAD_LO);
          pad_hi_d      = 1'b0;
          launch_d      = 1'b1;
          ret_d         = S_SQUEEZE;
          state_d       = S_PERM;
        end else begin
          state_idx_d   = aidx_q;
          state_wdata_d = PAD_LO;
          pad_hi_d      = 1'b1;
        end
      end

      S_PERM: begin
        if (launch_q) begin
          perm_en_d = 1'b1;
          launch_d  = 1'b0;
        end else if (PERM_DONE && !perm_en_q) begin
          state_d = ret_q;
          if (ret_q == S_ABSORB) begin
            in_ready_d  = 1'b1;
            state_idx_d = aidx_q;
          end else if (ret_q == S_SQUEEZE) begin
            out_valid_d = 1'b1;
            state_idx_d = sidx_q;
          end
        end
      end

      S_SQUEEZE: begin
        if (OUT_READY) begin
          ocnt_d = ocnt_q + OCNT_W'(1);
          if (ocnt_q == OCNT_LAST) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_idx_d = '0;
            state_d     = S_IDLE;
          end else if (sidx_q == LAST_LANE) begin
            // Rate exhausted: permute directly, no pending write to wait for.
            sidx_d      = '0;
            out_valid_d = 1'b0;
            perm_en_d   = 1'b1;
            ret_d       = S_SQUEEZE;
            state_d     = S_PERM;
          end else begin
            sidx_d      = sidx_q + IDX_W'(1);
            state_idx_d = sidx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      aidx_q        <= '0;
      sidx_q        <= '0;
      ocnt_q        <= '0;
      pad_hi_q      <= 1'b0;
      launch_q      <= 1'b0;
      in_ready_q    <= 1'b0;
      state_clr_q   <= 1'b0;
      state_we_q    <= 1'b0;
      state_idx_q   <= '0;
      state_wdata_q <= '0;
      perm_en_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      aidx_q        <= aidx_d;
      sidx_q        <= sidx_d;
      ocnt_q        <= ocnt_d;
      pad_hi_q      <= pad_hi_d;
      launch_q      <= launch_d;
      in_ready_q    <= in_ready_d;
      state_clr_q   <= state_clr_d;
      state_we_q    <= state_we_d;
      state_idx_q   <= state_idx_d;
      state_wdata_q <= state_wdata_d;
      perm_en_q     <= perm_en_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  assign IN_READY    = in_ready_q;
  assign STATE_CLR   = state_clr_q;
  assign STATE_WE    = state_we_q;
  assign STATE_IDX   = state_idx_q;
  assign STATE_WDATA = state_wdata_q;
  assign PERM_EN     = perm_en_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_DATA    = out_valid_q ? STATE_RDATA : '0;
  assign BUSY        = busy_q;
  assign DONE        = done_q;

endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keccak_sponge_ctrl
//   Directed bench for keccak_sponge_ctrl (OUT_WORDS=20). A behavioural state
//   array and a stand-in permutation core surround the DUT. Expected lane
//   writes and output words are queued as each test is set up; a monitor pops
//   and compares them whenever the DUT writes or presents an output word.
// -----------------------------------------------------------------------------
module tb_keccak_sponge_ctrl;

  localparam int RATE = 17;
  localparam int OUTW = 20;
  localparam logic [63:0] PAD_HI = 64'h8000_0000_0000_0000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1, START = 1'b0;
  logic [63:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0, IN_LAST = 1'b0;
  logic [3:0]  IN_BYTES = '0;
  logic        IN_READY, STATE_CLR, STATE_WE, PERM_EN, OUT_VALID, BUSY, DONE;
  logic [4:0]  STATE_IDX;
  logic [63:0] STATE_WDATA, STATE_RDATA, OUT_DATA;
  logic        PERM_DONE = 1'b0, OUT_READY = 1'b0;

  keccak_sponge_ctrl #(.RATE_WORDS(RATE), .OUT_WORDS(OUTW), .IDX_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .IN_BYTES(IN_BYTES),
    .IN_READY(IN_READY), .STATE_CLR(STATE_CLR), .STATE_WE(STATE_WE),
    .STATE_IDX(STATE_IDX), .STATE_WDATA(STATE_WDATA), .STATE_RDATA(STATE_RDATA),
    .PERM_EN(PERM_EN), .PERM_DONE(PERM_DONE),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_errors = 0;
  int n_perm = 0, n_done = 0, n_clr = 0, n_hs = 0;

  logic [63:0] mem    [32];   // state as seen by the DUT
  logic [63:0] ref_st [32];   // state predicted from the expected writes
  logic [4:0]  exp_idx_q [$];
  logic [63:0] exp_dat_q [$];
  logic [63:0] exp_out_q [$];
  int          exp_perms;

  assign STATE_RDATA = mem[STATE_IDX];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stand-in permutation: deterministic per-lane scramble.
  function automatic logic [63:0] perm_lane(input int i, input logic [63:0] v);
    return {v[55:0], v[63:56]} ^ (64'h0123_4567_89AB_CDEF + 64'(i));
  endfunction

  // Environment: state array and permutation core, three cycles per permutation.
  initial begin
    int cnt = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    forever begin
      @(negedge CLK);
      PERM_DONE = 1'b0;
      if (RESET) begin
        cnt = 0;
      end else begin
        if (STATE_CLR) for (int i = 0; i < 32; i++) mem[i] = '0;
        if (STATE_WE) mem[STATE_IDX] = mem[STATE_IDX] ^ STATE_WDATA;
        if (PERM_EN) begin
          n_perm++;
          check("perm_en_while_busy", 64'(cnt != 0), 64'd0);
          cnt = 3;
        end else if (cnt != 0) begin
          cnt--;
          if (cnt == 0) begin
            for (int i = 0; i < 25; i++) mem[i] = perm_lane(i, mem[i]);
            PERM_DONE = 1'b1;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge CLK);
      if (STATE_WE) begin
        if (exp_idx_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: got lane %0d data %h required none", STATE_IDX, STATE_WDATA);
        end else begin
          check("write_lane", 64'(STATE_IDX), 64'(exp_idx_q.pop_front()));
          check("write_data", STATE_WDATA, exp_dat_q.pop_front());
        end
      end
      if (OUT_VALID) begin
        if (exp_out_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_out: got %h required none", OUT_DATA);
        end else begin
          // Checked on stalled cycles too, so OUT_DATA must hold its word.
          check("out_data", OUT_DATA, exp_out_q[0]);
          if (OUT_READY) begin
            void'(exp_out_q.pop_front());
            n_hs++;
          end
        end
      end
      if (STATE_CLR) n_clr++;
      if (DONE) n_done++;
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1 OUT_READY = ~OUT_READY;
    end
  end

  initial begin
    repeat (50000) @(posedge CLK);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---- expectation helpers ----
  task automatic exp_begin();
    for (int i = 0; i < 32; i++) ref_st[i] = '0;
    exp_perms = 0;
  endtask

  task automatic exp_wr(input int idx, input logic [63:0] d);
    exp_idx_q.push_back(5'(idx));
    exp_dat_q.push_back(d);
    ref_st[idx] = ref_st[idx] ^ d;
  endtask

  task automatic exp_perm();
    for (int i = 0; i < 25; i++) ref_st[i] = perm_lane(i, ref_st[i]);
    exp_perms++;
  endtask

  task automatic exp_squeeze();
    int s = 0;
    exp_perm();
    for (int k = 0; k < OUTW; k++) begin
      if (s == RATE) begin
        exp_perm();
        s = 0;
      end
      exp_out_q.push_back(ref_st[s]);
      s++;
    end
  endtask

  // ---- stimulus helpers (entered and left at posedge+1) ----
  task automatic start_pulse();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int t = 0;
    IN_DATA = d; IN_LAST = last; IN_BYTES = nb; IN_VALID = 1'b1;
    @(negedge CLK);
    while (!IN_READY && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("in_ready_wait", 64'(IN_READY), 64'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_LAST = 1'b0; IN_BYTES = '0; IN_DATA = '0;
  endtask

  function automatic logic [63:0] word(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k + 1);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      64'(BUSY),      64'd0);
    check({tag, "_in_ready"},  64'(IN_READY),  64'd0);
    check({tag, "_state_clr"}, 64'(STATE_CLR), 64'd0);
    check({tag, "_state_we"},  64'(STATE_WE),  64'd0);
    check({tag, "_state_idx"}, 64'(STATE_IDX), 64'd0);
    check({tag, "_wdata"},     STATE_WDATA,    64'd0);
    check({tag, "_perm_en"},   64'(PERM_EN),   64'd0);
    check({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    check({tag, "_out_data"},  OUT_DATA,       64'd0);
    check({tag, "_done"},      64'(DONE),      64'd0);
  endtask

  int perm0, done0, clr0, hs0;

  task automatic begin_run();
    perm0 = n_perm; done0 = n_done; clr0 = n_clr; hs0 = n_hs;
    start_pulse();
  endtask

  task automatic end_run(input string tag);
    int t = 0;
    while (n_done == done0 && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_done_seen"}, 64'(n_done - done0), 64'd1);
    repeat (4) @(negedge CLK);
    check({tag, "_done_once"},  64'(n_done - done0),   64'd1);
    check({tag, "_perm_count"}, 64'(n_perm - perm0),   64'(exp_perms));
    check({tag, "_clr_count"},  64'(n_clr - clr0),     64'd1);
    check({tag, "_handshakes"}, 64'(n_hs - hs0),       64'(OUTW));
    check({tag, "_writes_left"}, 64'(exp_idx_q.size()), 64'd0);
    check({tag, "_outs_left"},  64'(exp_out_q.size()), 64'd0);
    check({tag, "_busy_after"}, 64'(BUSY),             64'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check_idle("reset");
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Empty message: 0x1F at lane 0, 0x80 at lane 16.
    exp_begin();
    exp_wr(0, 64'h1F);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    @(negedge CLK);
    check("busy_after_start", 64'(BUSY), 64'd1);
    @(posedge CLK); #1;
    send(64'h1234_5678_9ABC_DEF0, 1'b1, 4'd0);
    end_run("empty");

    // Three-byte message.
    exp_begin();
    exp_wr(0, 64'h0000_0000_1FAA_BBCC);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    send(64'h0000_0000_00AA_BBCC, 1'b1, 4'd3);
    end_run("bytes3");

    // Same length, bytes above IN_BYTES must be masked away.
    exp_begin();
    exp_wr(0, 64'h0000_0000_1FAA_BBCC);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    send(64'hFFFF_FFFF_FFAA_BBCC, 1'b1, 4'd3);
    end_run("bytes3_mask");

    // Two full words: padding at lane 2 and lane 16.
    exp_begin();
    exp_wr(0, word(0));
    exp_wr(1, word(1));
    exp_wr(2, 64'h1F);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    send(word(0), 1'b0, 4'd0);
    send(word(1), 1'b1, 4'd8);
    end_run("two_full");

    // 17 full words: permute, pad a fresh block, permute again. A START
    // mid-absorb must be ignored.
    exp_begin();
    for (int k = 0; k < RATE; k++) exp_wr(k, word(k));
    exp_perm();
    exp_wr(0, 64'h1F);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    for (int k = 0; k < RATE; k++) begin
      if (k == 3) START = 1'b1;
      send(word(k), (k == RATE - 1), (k == RATE - 1) ? 4'd8 : 4'd0);
      START = 1'b0;
    end
    end_run("full_block");

    // Partial last word at lane 16: padding folded into one write.
    exp_begin();
    for (int k = 0; k < RATE - 1; k++) exp_wr(k, word(k));
    exp_wr(16, 64'h8000_1F11_2233_4455);
    exp_squeeze();
    begin_run();
    for (int k = 0; k < RATE - 1; k++) send(word(k), 1'b0, 4'd0);
    send(64'h0000_0011_2233_4455, 1'b1, 4'd5);
    end_run("lane16_last");

    // Reset after five absorbed words aborts the request.
    exp_begin();
    for (int k = 0; k < 5; k++) exp_wr(k, word(k + 40));
    perm0 = n_perm;
    start_pulse();
    for (int k = 0; k < 5; k++) send(word(k + 40), 1'b0, 4'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_idle("abort");
    repeat (5) @(negedge CLK);
    check("abort_no_perm", 64'(n_perm - perm0), 64'd0);
    check("abort_writes_left", 64'(exp_idx_q.size()), 64'd0);
    @(posedge CLK); #1;

    // Normal operation resumes.
    exp_begin();
    exp_wr(0, 64'h1F);
    exp_wr(16, PAD_HI);
    exp_squeeze();
    begin_run();
    send(64'h0, 1'b1, 4'd0);
    end_run("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
